// File: rtl/stepper_motion_tracker.sv
// Motion state tracker for a stepper half-step index stream: direction, signed position,
// step period, skipped-step detection and fault handling, all outputs registered.
module stepper_motion_tracker #(
    parameter int POS_WIDTH     = 16,
    parameter int PERIOD_WIDTH  = 20,
    parameter int IDLE_TIMEOUT  = 100000,
    parameter int INVALID_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              step,
    input  logic                    invalid,
    input  logic                    position_zero,
    input  logic                    clear_fault,
    output logic [POS_WIDTH-1:0]    position,
    output logic                    direction,
    output logic                    moving,
    output logic                    step_pulse,
    output logic [PERIOD_WIDTH-1:0] step_period,
    output logic                    period_valid,
    output logic                    skip_error,
    output logic                    fault,
    output logic [1:0]              state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD   = 2'd1,
        REV   = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam int INV_W = $clog2(INVALID_LIMIT + 1);
    localparam logic [INV_W-1:0]        INV_LIM    = INV_W'(INVALID_LIMIT);
    localparam logic [INV_W-1:0]        INV_LIM_M1 = INV_W'(INVALID_LIMIT - 1);
    localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX = '1;
    localparam logic [PERIOD_WIDTH-1:0] TIMEOUT_M1 = PERIOD_WIDTH'(IDLE_TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [2:0]              prev_step_q, prev_step_d;
    logic [INV_W-1:0]        inv_cnt_q, inv_cnt_d;
    logic [PERIOD_WIDTH-1:0] period_cnt_q, period_cnt_d;
    logic [POS_WIDTH-1:0]    position_q, position_d;
    logic                    direction_q, direction_d;
    logic                    step_pulse_q, step_pulse_d;
    logic [PERIOD_WIDTH-1:0] step_period_q, step_period_d;
    logic                    period_valid_q, period_valid_d;
    logic                    skip_error_q, skip_error_d;

    logic [2:0]              delta;
    logic [POS_WIDTH-1:0]    delta_ext;
    logic [POS_WIDTH-1:0]    pos_base;
    logic                    fwd_ev, rev_ev, amb, inv_trip, fault_cond, step_ev, same_dir;

    always_comb begin
        delta      = step - prev_step_q;
        // A 3-bit two's complement delta of 1,2,6,7 is exactly +1,+2,-2,-1 half-steps.
        delta_ext  = {{(POS_WIDTH-3){delta[2]}}, delta};
        fwd_ev     = (delta == 3'd1) || (delta == 3'd2);
        rev_ev     = (delta == 3'd6) || (delta == 3'd7);
        amb        = (delta != 3'd0) && !fwd_ev && !rev_ev;
        inv_trip   = invalid && (inv_cnt_q >= INV_LIM_M1);
        fault_cond = amb || inv_trip;
        step_ev    = (state_q != FAULT) && (fwd_ev || rev_ev) && !fault_cond;
        same_dir   = ((state_q == FWD) && fwd_ev) || ((state_q == REV) && rev_ev);

        state_d        = state_q;
        prev_step_d    = step;
        inv_cnt_d      = '0;
        period_cnt_d   = (period_cnt_q == PERIOD_MAX) ? PERIOD_MAX : period_cnt_q + 1'b1;
        direction_d    = direction_q;
        step_pulse_d   = step_ev;
        step_period_d  = step_period_q;
        period_valid_d = 1'b0;
        skip_error_d   = step_ev && ((delta == 3'd2) || (delta == 3'd6));

        if (invalid) begin
            inv_cnt_d = (inv_cnt_q == INV_LIM) ? inv_cnt_q : inv_cnt_q + 1'b1;
        end

        // Zeroing applies first so a coincident step lands on the fresh origin.
        pos_base   = position_zero ? '0 : position_q;
        position_d = step_ev ? pos_base + delta_ext : pos_base;

        if (step_ev) begin
            period_cnt_d = '0;
            direction_d  = fwd_ev;
        end

        case (state_q)
            IDLE: begin
                if (fault_cond)   state_d = FAULT;
                else if (step_ev) state_d = fwd_ev ? FWD : REV;
            end
            FWD, REV: begin
                if (fault_cond) begin
                    state_d = FAULT;
                end else if (step_ev) begin
                    if (same_dir) begin
                        step_period_d  = (period_cnt_q == PERIOD_MAX) ? PERIOD_MAX
                                                                      : period_cnt_q + 1'b1;
                        period_valid_d = 1'b1;
                    end else begin
                        state_d = fwd_ev ? FWD : REV;
                    end
                end else if (period_cnt_q >= TIMEOUT_M1) begin
                    state_d = IDLE;
                end
            end
            FAULT: begin
                if (clear_fault && !fault_cond) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            prev_step_q    <= '0;
            inv_cnt_q      <= '0;
            period_cnt_q   <= '0;
            position_q     <= '0;
            direction_q    <= 1'b0;
            step_pulse_q   <= 1'b0;
            step_period_q  <= '0;
            period_valid_q <= 1'b0;
            skip_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_step_q    <= prev_step_d;
            inv_cnt_q      <= inv_cnt_d;
            period_cnt_q   <= period_cnt_d;
            position_q     <= position_d;
            direction_q    <= direction_d;
            step_pulse_q   <= step_pulse_d;
            step_period_q  <= step_period_d;
            period_valid_q <= period_valid_d;
            skip_error_q   <= skip_error_d;
        end
    end

    assign position     = position_q;
    assign direction    = direction_q;
    assign moving       = (state_q == FWD) || (state_q == REV);
    assign step_pulse   = step_pulse_q;
    assign step_period  = step_period_q;
    assign period_valid = period_valid_q;
    assign skip_error   = skip_error_q;
    assign fault        = (state_q == FAULT);
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_stepper_motion_tracker.sv
// Directed bench for stepper_motion_tracker with hand-computed expectations;
// inputs change 1ns after the rising edge, outputs are checked at the same point.
module tb_stepper_motion_tracker;

    logic        clk;
    logic        reset;
    logic [2:0]  step;
    logic        invalid;
    logic        position_zero;
    logic        clear_fault;
    logic [15:0] position;
    logic        direction;
    logic        moving;
    logic        step_pulse;
    logic [19:0] step_period;
    logic        period_valid;
    logic        skip_error;
    logic        fault;
    logic [1:0]  state_dbg;

    int checks;
    int failures;

    stepper_motion_tracker #(
        .POS_WIDTH    (16),
        .PERIOD_WIDTH (20),
        .IDLE_TIMEOUT (40),
        .INVALID_LIMIT(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .step         (step),
        .invalid      (invalid),
        .position_zero(position_zero),
        .clear_fault  (clear_fault),
        .position     (position),
        .direction    (direction),
        .moving       (moving),
        .step_pulse   (step_pulse),
        .step_period  (step_period),
        .period_valid (period_valid),
        .skip_error   (skip_error),
        .fault        (fault),
        .state_dbg    (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        step = 3'd0;
        invalid = 1'b0;
        position_zero = 1'b0;
        clear_fault = 1'b0;
        ticks(2);

        chk("rst_position", 32'(position), 32'h0);
        chk("rst_direction", 32'(direction), 32'h0);
        chk("rst_moving", 32'(moving), 32'h0);
        chk("rst_step_pulse", 32'(step_pulse), 32'h0);
        chk("rst_step_period", 32'(step_period), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        reset = 1'b1;
        ticks(2);

        // 0->1->2->3, ten cycles apart
        step = 3'd1; tick();
        chk("s1_position", 32'(position), 32'h1);
        chk("s1_step_pulse", 32'(step_pulse), 32'h1);
        chk("s1_direction", 32'(direction), 32'h1);
        chk("s1_moving", 32'(moving), 32'h1);
        chk("s1_period_valid", 32'(period_valid), 32'h0);
        tick();
        chk("s1_pulse_off", 32'(step_pulse), 32'h0);
        ticks(8);
        step = 3'd2; tick();
        chk("s2_position", 32'(position), 32'h2);
        chk("s2_period_valid", 32'(period_valid), 32'h1);
        chk("s2_step_period", 32'(step_period), 32'd10);
        tick();
        chk("s2_pv_off", 32'(period_valid), 32'h0);
        ticks(8);
        step = 3'd3; tick();
        chk("s3_position", 32'(position), 32'h3);
        chk("s3_period_valid", 32'(period_valid), 32'h1);
        chk("s3_step_period", 32'(step_period), 32'd10);
        chk("s3_state_fwd", 32'(state_dbg), 32'h1);

        // climb by +2 every cycle up to 0x7FFF, then wrap with +1
        for (int i = 0; i < 16382; i++) begin
            step = step + 3'd2;
            tick();
        end
        chk("climb_position", 32'(position), 32'h7FFF);
        chk("climb_skip", 32'(skip_error), 32'h1);
        step = step + 3'd1; tick();
        chk("wrap_position", 32'(position), 32'h8000);
        chk("wrap_period_valid", 32'(period_valid), 32'h1);
        chk("wrap_step_period", 32'(step_period), 32'd1);
        chk("wrap_skip", 32'(skip_error), 32'h0);
        step = step - 3'd1; tick();
        chk("rev_position", 32'(position), 32'h7FFF);
        chk("rev_direction", 32'(direction), 32'h0);
        chk("rev_period_valid", 32'(period_valid), 32'h0);
        chk("rev_state", 32'(state_dbg), 32'h2);

        // reverse to index 4, skip forward to 6, then ambiguous jump to 1
        step = 3'd6; tick();
        step = 3'd5; tick();
        step = 3'd4; tick();
        chk("rev3_position", 32'(position), 32'h7FFC);
        step = 3'd6; tick();
        chk("skip_position", 32'(position), 32'h7FFE);
        chk("skip_error", 32'(skip_error), 32'h1);
        chk("skip_direction", 32'(direction), 32'h1);
        chk("skip_period_valid", 32'(period_valid), 32'h0);
        tick();
        chk("skip_off", 32'(skip_error), 32'h0);
        step = 3'd1; tick();
        chk("amb_fault", 32'(fault), 32'h1);
        chk("amb_moving", 32'(moving), 32'h0);
        chk("amb_position", 32'(position), 32'h7FFE);
        step = 3'd2; tick();
        chk("flt_position", 32'(position), 32'h7FFE);
        chk("flt_step_pulse", 32'(step_pulse), 32'h0);
        clear_fault = 1'b1; tick();
        clear_fault = 1'b0;
        chk("clr_fault", 32'(fault), 32'h0);
        chk("clr_idle", 32'(state_dbg), 32'h0);
        step = 3'd3; tick();
        chk("post_clr_position", 32'(position), 32'h7FFF);
        chk("post_clr_skip", 32'(skip_error), 32'h0);
        chk("post_clr_moving", 32'(moving), 32'h1);
        clear_fault = 1'b1; tick();
        clear_fault = 1'b0;
        chk("clr_ignored", 32'(moving), 32'h1);

        // invalid run: 3 cycles is tolerated, 4 consecutive forces FAULT
        invalid = 1'b1; ticks(3);
        chk("inv3_fault", 32'(fault), 32'h0);
        invalid = 1'b0; tick();
        chk("inv_gap_fault", 32'(fault), 32'h0);
        invalid = 1'b1; ticks(3);
        chk("inv3b_fault", 32'(fault), 32'h0);
        tick();
        chk("inv4_fault", 32'(fault), 32'h1);
        invalid = 1'b0;
        clear_fault = 1'b1; tick();
        clear_fault = 1'b0;
        chk("inv_clr_fault", 32'(fault), 32'h0);

        // idle timeout after 40 quiet cycles
        step = 3'd4; tick();
        chk("to_start_position", 32'(position), 32'h8000);
        chk("to_start_moving", 32'(moving), 32'h1);
        ticks(39);
        chk("to_39_moving", 32'(moving), 32'h1);
        tick();
        chk("to_40_moving", 32'(moving), 32'h0);
        step = 3'd5; tick();
        chk("to_resume_position", 32'(position), 32'h8001);
        chk("to_resume_pv", 32'(period_valid), 32'h0);
        chk("to_resume_moving", 32'(moving), 32'h1);

        // zero coincident with a reverse step, then zero alone
        position_zero = 1'b1; step = 3'd4; tick();
        position_zero = 1'b0;
        chk("zero_step_position", 32'(position), 32'hFFFF);
        chk("zero_step_direction", 32'(direction), 32'h0);
        position_zero = 1'b1; tick();
        position_zero = 1'b0;
        chk("zero_only_position", 32'(position), 32'h0);

        // reset mid-move
        step = 3'd5; tick();
        chk("pre_rst_position", 32'(position), 32'h1);
        reset = 1'b0; #1;
        chk("midrst_position", 32'(position), 32'h0);
        chk("midrst_moving", 32'(moving), 32'h0);
        chk("midrst_direction", 32'(direction), 32'h0);
        chk("midrst_step_period", 32'(step_period), 32'h0);
        chk("midrst_step_pulse", 32'(step_pulse), 32'h0);
        reset = 1'b1;
        ticks(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
